// File: rtl/screen_pkg.sv
// rtl/screen_pkg.sv - shared screen encodings and pixel widths for the screen sequencer
package screen_pkg;

    localparam int RGB_W = 12;
    localparam int CH_W  = 4;
    localparam int NUM_CH = RGB_W / CH_W;

    // Darkest fade level; each step halves the channel intensity.
    localparam logic [1:0] FADE_DARK = 2'd3;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_PLAY  = 2'd1,
        ST_P1WIN = 2'd2,
        ST_P2WIN = 2'd3
    } screenState_t;

endpackage

// File: rtl/screen_fader.sv
// rtl/screen_fader.sv - per-channel right shift of a 12-bit RGB pixel by the fade level
module screen_fader
    import screen_pkg::*;
(
    input  logic [RGB_W-1:0] rgb,
    input  logic [1:0]       level,
    output logic [RGB_W-1:0] faded
);

    // Each 4-bit channel is dimmed independently so no bits bleed between colours.
    always_comb begin
        faded = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            faded[c*CH_W +: CH_W] = rgb[c*CH_W +: CH_W] >> level;
        end
    end

endmodule

// File: rtl/screen_sequencer.sv
// rtl/screen_sequencer.sv - Battle Tank screen FSM with frame-aligned switching and fade-in
module screen_sequencer
    import screen_pkg::*;
#(
    parameter int WIN_HOLD_FRAMES = 300,
    parameter int MIN_HOLD_FRAMES = 60,
    parameter int FADE_FRAMES     = 4
) (
    input  logic             pClk,
    input  logic             pReset,
    input  logic             pFrame_tick,
    input  logic             pStart_btn,
    input  logic             pP1_dead,
    input  logic             pP2_dead,
    input  logic [RGB_W-1:0] pStart_in,
    input  logic [RGB_W-1:0] pGame_in,
    input  logic [RGB_W-1:0] pP1win_in,
    input  logic [RGB_W-1:0] pP2win_in,
    output logic [RGB_W-1:0] pScreen_out,
    output logic [1:0]       pState,
    output logic             pGame_reset
);

    localparam int HOLD_W = $clog2(WIN_HOLD_FRAMES + 1);
    localparam int FADE_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;

    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(WIN_HOLD_FRAMES);
    localparam logic [HOLD_W-1:0] HOLD_MIN  = HOLD_W'(MIN_HOLD_FRAMES);
    localparam logic [FADE_W-1:0] FADE_LAST = FADE_W'(FADE_FRAMES - 1);

    screenState_t      state;
    logic [HOLD_W-1:0] holdCnt;
    logic [HOLD_W-1:0] holdNext;
    logic [1:0]        fadeLevel;
    logic [FADE_W-1:0] fadeCnt;
    logic              startReq;
    logic              prevBtn;
    logic              btnRise;
    logic              winExit;
    logic [RGB_W-1:0]  srcPix;
    logic [RGB_W-1:0]  fadedPix;

    assign pState  = state;
    assign btnRise = pStart_btn & ~prevBtn;

    // Win-screen exit is judged on the count this tick will produce, so the
    // Nth tick after entry is the one that reaches N.
    always_comb begin
        holdNext = (holdCnt == HOLD_MAX) ? HOLD_MAX : holdCnt + 1'b1;
        winExit  = (holdNext == HOLD_MAX) || (startReq && (holdNext >= HOLD_MIN));
    end

    // Source select uses the registered state, so a new screen appears the cycle after its tick.
    always_comb begin
        srcPix = pStart_in;
        unique case (state)
            ST_START: srcPix = pStart_in;
            ST_PLAY:  srcPix = pGame_in;
            ST_P1WIN: srcPix = pP1win_in;
            ST_P2WIN: srcPix = pP2win_in;
        endcase
    end

    screen_fader uFader (
        .rgb   (srcPix),
        .level (fadeLevel),
        .faded (fadedPix)
    );

    // Screen FSM, start-request latch, hold/fade counters and the registered pixel.
    always_ff @(posedge pClk) begin
        if (pReset) begin
            state       <= ST_START;
            pScreen_out <= '0;
            pGame_reset <= 1'b0;
            holdCnt     <= '0;
            startReq    <= 1'b0;
            fadeLevel   <= FADE_DARK;
            fadeCnt     <= '0;
            prevBtn     <= 1'b0;
        end else begin
            prevBtn     <= pStart_btn;
            pGame_reset <= 1'b0;
            pScreen_out <= fadedPix;

            if (btnRise) begin
                startReq <= 1'b1;
            end

            if (pFrame_tick) begin
                // Fade advances every tick; any transition below restarts it.
                if (fadeLevel != 2'd0) begin
                    if (fadeCnt == FADE_LAST) begin
                        fadeLevel <= fadeLevel - 2'd1;
                        fadeCnt   <= '0;
                    end else begin
                        fadeCnt <= fadeCnt + 1'b1;
                    end
                end

                unique case (state)
                    ST_START: begin
                        if (startReq) begin
                            state       <= ST_PLAY;
                            pGame_reset <= 1'b1;
                            startReq    <= 1'b0;
                            fadeLevel   <= FADE_DARK;
                            fadeCnt     <= '0;
                        end
                    end

                    ST_PLAY: begin
                        // A press during play means nothing; drop it so it cannot skip the win screen.
                        startReq <= 1'b0;
                        if (pP1_dead || pP2_dead) begin
                            if (pP1_dead && pP2_dead) begin
                                state <= ST_START;
                            end else if (pP2_dead) begin
                                state <= ST_P1WIN;
                            end else begin
                                state <= ST_P2WIN;
                            end
                            holdCnt   <= '0;
                            fadeLevel <= FADE_DARK;
                            fadeCnt   <= '0;
                        end
                    end

                    ST_P1WIN, ST_P2WIN: begin
                        holdCnt <= holdNext;
                        if (winExit) begin
                            state     <= ST_START;
                            startReq  <= 1'b0;
                            holdCnt   <= '0;
                            fadeLevel <= FADE_DARK;
                            fadeCnt   <= '0;
                        end
                    end
                endcase
            end
        end
    end

endmodule
